// File: rtl/ifu.sv
// Fetch stage plus the F/D pipeline register of a MIPS-style core.
// Redirects from the instruction in D take effect one edge later, so the delay slot always executes.
module ifu #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096,
    localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush_d,
    input  logic          br_taken,
    input  logic [31:0]   ext_imm,
    input  logic          jump,
    input  logic [25:0]   j_index,
    input  logic          jr,
    input  logic [31:0]   jr_addr,
    input  logic [31:0]   imem_rdata,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   pc_f,
    output logic [31:0]   instr_d,
    output logic [31:0]   pc_d,
    output logic [31:0]   pc8_d,
    output logic          valid_d,
    output logic          adel
);

    logic [31:0] pc_f_q,    pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q,    pc_d_d;
    logic        valid_d_q, valid_d_d;
    logic        adel_q,    adel_d;

    logic [31:0] pc_seq;
    logic [31:0] pc_d_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;
    logic [31:0] jr_tgt;
    logic        redirect_en;
    logic [31:0] word_off;

    assign pc_seq      = pc_f_q + 32'd4;
    assign pc_d_plus4  = pc_d_q + 32'd4;
    assign jump_tgt    = (pc_d_plus4 & 32'hF000_0000) | {4'b0000, j_index, 2'b00};
    assign br_tgt      = pc_d_plus4 + ext_imm;
    assign jr_tgt      = jr_addr & 32'hFFFF_FFFC;
    assign redirect_en = valid_d_q & ~stall;

    // Word offset from the reset PC; wraps naturally modulo 2^32 below PC_RESET.
    assign word_off = (pc_f_q - PC_RESET) >> 2;

    generate
        if ((IMEM_WORDS & (IMEM_WORDS - 1)) == 0) begin : g_addr_pow2
            assign imem_addr = AW'(word_off);
        end else begin : g_addr_mod
            logic [31:0] word_mod;
            assign word_mod  = word_off % IMEM_WORDS;
            assign imem_addr = AW'(word_mod);
        end
    endgenerate

    always_comb begin
        pc_f_d = pc_f_q;
        if (!stall) begin
            pc_f_d = pc_seq;
            if (redirect_en) begin
                if (jr) begin
                    pc_f_d = jr_tgt;
                end else if (jump) begin
                    pc_f_d = jump_tgt;
                end else if (br_taken) begin
                    pc_f_d = br_tgt;
                end
            end
        end
    end

    // Flush overrides both the normal load and a stall hold of the D register.
    always_comb begin
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        valid_d_d = valid_d_q;
        if (!stall) begin
            instr_d_d = imem_rdata;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
        end
        if (flush_d) begin
            instr_d_d = '0;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b0;
        end
    end

    always_comb begin
        adel_d = adel_q;
        if (redirect_en && jr && (jr_addr[1:0] != 2'b00)) begin
            adel_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f_q    <= PC_RESET;
            instr_d_q <= '0;
            pc_d_q    <= PC_RESET - 32'd4;
            valid_d_q <= 1'b0;
            adel_q    <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            valid_d_q <= valid_d_d;
            adel_q    <= adel_d;
        end
    end

    assign pc_f    = pc_f_q;
    assign instr_d = instr_d_q;
    assign pc_d    = pc_d_q;
    assign pc8_d   = pc_d_q + 32'd8;
    assign valid_d = valid_d_q;
    assign adel    = adel_q;

endmodule
